instr_fetch_queue: RTL and testbench

- Upstream fetch stage of the processor. It prefetches 8-bit opcodes from instruction memory into a small FIFO, in the style of the 8086 prefetch queue.
- It drives the IR register consumed by the control unit, and loads IR on the control unit's ir_load pulse.
- It keeps the architectural PC, meaning the address of the opcode currently in IR.
- A flush redirects fetching after JMP/CALL/RET/GOTO/JZ/JNZ.

---
 rtl/instr_fetch_queue_pkg.sv | 26 ++
 rtl/instr_fetch_queue_sync_fifo.sv | 47 ++++
 rtl/instr_fetch_queue.sv | 102 ++++++++++
 tb/tb_instr_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the fetch unit: opcode map (common with the control
// unit), fetch FSM encoding and default widths.
package instr_fetch_queue_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h81;
  localparam logic [7:0] OP_CALL = 8'h82;
  localparam logic [7:0] OP_RET  = 8'h83;
  localparam logic [7:0] OP_GOTO = 8'h84;
  localparam logic [7:0] OP_JZ   = 8'h85;
  localparam logic [7:0] OP_JNZ  = 8'h87;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// DEPTH x DATA_W circular buffer with occupancy count; clear empties it in
// one cycle (used by flush).
module sync_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue feeding IR/PC to the control unit; one read outstanding max.
// Optional macro FETCH_BYPASS_EN: serve ir straight from mem_data when empty.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_valid,
  input  logic                     ir_load,
  output logic [DATA_W-1:0]        ir,
  output logic [ADDR_W-1:0]        pc,
  output logic                     fetch_stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_addr,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] fetch_ptr, fetch_ptr_nxt, pc_next;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  cnt_after;
  logic              accept, bypass, push, pop, full, empty, space_after;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (mem_data),
    .dout  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  // Responses are only meaningful while a live request is in flight.
  assign accept = (state == ST_REQ) && mem_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = accept && empty && ir_load && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push        = accept && !flush && !bypass;
  assign pop         = ir_load && !empty && !flush;
  assign fetch_stall = empty && !bypass;
  assign mem_rd      = (state == ST_REQ);

  assign cnt_after   = q_count + CNT_W'(push) - CNT_W'(pop);
  assign space_after = cnt_after < CNT_W'(DEPTH);

  always_comb begin
    state_nxt     = state;
    fetch_ptr_nxt = fetch_ptr;
    case (state)
      ST_IDLE:    if (!full) state_nxt = ST_REQ;
      ST_REQ:     if (accept) state_nxt = space_after ? ST_REQ : ST_IDLE;
      ST_DISCARD: if (mem_valid) state_nxt = ST_REQ;
      default:    state_nxt = ST_IDLE;
    endcase
    if (accept) fetch_ptr_nxt = fetch_ptr + ADDR_W'(1);
    // A read still in flight at flush time must be swallowed before refetching.
    if (flush) begin
      fetch_ptr_nxt = flush_addr;
      state_nxt     = (state != ST_IDLE && !mem_valid) ? ST_DISCARD : ST_REQ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      fetch_ptr <= '0;
      pc_next   <= '0;
      pc        <= '0;
      ir        <= '0;
      mem_addr  <= '0;
    end else begin
      state     <= state_nxt;
      fetch_ptr <= fetch_ptr_nxt;
      if (state_nxt == ST_REQ) mem_addr <= fetch_ptr_nxt;
      if (flush) begin
        pc_next <= flush_addr;
      end else if (pop || bypass) begin
        ir      <= pop ? head : mem_data;
        pc      <= pc_next;
        pc_next <= pc_next + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue with a variable-latency memory model.
module tb_instr_fetch_queue;

  typedef struct { logic [7:0] op; logic [7:0] pc; } exp_t;

  logic       clock = 0, reset = 1, ir_load = 0, flush = 0;
  logic [7:0] flush_addr = 0;
  logic       mem_rd, mem_valid, fetch_stall;
  logic [7:0] mem_addr, mem_data, ir, pc;
  logic [2:0] q_count;

  logic [7:0] imem [256];
  logic       rsp_valid = 0, rsp_busy = 0, rsp_en = 1;
  logic [7:0] rsp_data = 0;
  int         rsp_cnt = 0, rsp_delay = 1;
  logic       stray_valid = 0;
  logic [7:0] stray_data = 0;
  logic [7:0] req_log [$];
  exp_t       sb [$];
  bit         ovf_seen = 0;
  int         tests = 0, fails = 0;
  logic [7:0] last_ir = 0, last_pc = 0;

  assign mem_valid = rsp_valid | stray_valid;
  assign mem_data  = stray_valid ? stray_data : rsp_data;

  instr_fetch_queue #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_valid(mem_valid), .ir_load(ir_load), .ir(ir),
    .pc(pc), .fetch_stall(fetch_stall), .flush(flush), .flush_addr(flush_addr),
    .q_count(q_count));

  always #5 clock = ~clock;

  // Memory: latches a request, answers rsp_delay cycles later with a 1-cycle strobe.
  always @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 0;
      rsp_busy  <= 0;
    end else begin
      rsp_valid <= 0;
      if (rsp_busy) begin
        if (rsp_cnt == 0) begin rsp_valid <= 1; rsp_busy <= 0; end
        else rsp_cnt <= rsp_cnt - 1;
      end else if (mem_rd && rsp_en && !rsp_valid) begin
        rsp_busy <= 1;
        rsp_cnt  <= rsp_delay - 1;
        rsp_data <= imem[mem_addr];
        req_log.push_back(mem_addr);
      end
    end
  end

  always @(negedge clock) if (!reset && q_count > 3'd4) ovf_seen <= 1;

  task automatic init_mem();
    for (int a = 0; a < 256; a++) imem[a] = 8'(a) ^ 8'hA5;
    imem[0] = 8'h01; imem[1] = 8'h02; imem[2] = 8'h03; imem[3] = 8'h04;
  endtask

  task automatic sb_load(input logic [7:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc = 8'(start + i);
      e.op = imem[e.pc];
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; ir_load = 0; flush = 0; stray_valid = 0; rsp_en = 1;
    init_mem();
    sb.delete();
    repeat (2) @(negedge clock);
    req_log.delete();
    reset = 0;
  endtask

  // Waits (bounded) for a non-empty queue and issues one ir_load pulse.
  task automatic serve(output bit ok);
    int n;
    n = 0;
    while (fetch_stall !== 1'b0 && n < 100) begin @(negedge clock); n++; end
    ok = (fetch_stall === 1'b0);
    if (ok) begin ir_load = 1; @(negedge clock); ir_load = 0; end
  endtask

  task automatic test_reset();
    init_mem();
    @(negedge clock); reset = 1;
    repeat (2) @(negedge clock);
    tests++; if (ir !== 8'h00)       begin fails++; $display("FAIL reset_ir got %h exp 00", ir); end
    tests++; if (pc !== 8'h00)       begin fails++; $display("FAIL reset_pc got %h exp 00", pc); end
    tests++; if (mem_rd !== 1'b0)    begin fails++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
    tests++; if (q_count !== 3'd0)   begin fails++; $display("FAIL reset_q_count got %0d exp 0", q_count); end
    tests++; if (fetch_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b exp 1", fetch_stall); end
    // stray strobe while IDLE must be ignored
    reset = 0; stray_data = 8'hEE; stray_valid = 1;
    @(negedge clock); stray_valid = 0;
    tests++; if (q_count !== 3'd0) begin fails++; $display("FAIL idle_stray_valid q_count got %0d exp 0", q_count); end
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00)
      begin fails++; $display("FAIL first_req got rd=%b addr=%h exp rd=1 addr=00", mem_rd, mem_addr); end
  endtask

  task automatic test_fill();
    int n;
    rsp_delay = 1;
    do_reset();
    sb_load(8'h00, 16);
    n = 0;
    while (!(q_count === 3'd4 && mem_rd === 1'b0) && n < 60) begin @(negedge clock); n++; end
    tests++; if (q_count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", q_count); end
    tests++; if (mem_rd !== 1'b0)  begin fails++; $display("FAIL fill_idle mem_rd got %b exp 0", mem_rd); end
    tests++; if (mem_addr !== 8'h03) begin fails++; $display("FAIL fill_last_addr got %h exp 03", mem_addr); end
    tests++; if (req_log.size() != 4 || req_log[0] !== 8'h00 || req_log[3] !== 8'h03)
      begin fails++; $display("FAIL fill_req_addrs got n=%0d exp 4 reads 00..03", req_log.size()); end
    repeat (3) @(negedge clock);
    tests++; if (mem_rd !== 1'b0 || q_count !== 3'd4)
      begin fails++; $display("FAIL fill_hold got rd=%b cnt=%0d exp rd=0 cnt=4", mem_rd, q_count); end
  endtask

  task automatic test_drain();
    exp_t e;
    bit   ok;
    ir_load = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      e = sb.pop_front();
      tests++; if (ir !== e.op || pc !== e.pc)
        begin fails++; $display("FAIL drain_%0d got ir=%h pc=%h exp ir=%h pc=%h", i, ir, pc, e.op, e.pc); end
    end
    ir_load = 0;
    tests++; if (q_count !== 3'd0 || mem_rd !== 1'b1 || mem_addr !== 8'h04)
      begin fails++; $display("FAIL refetch got cnt=%0d rd=%b addr=%h exp 0 1 04", q_count, mem_rd, mem_addr); end
    serve(ok);
    e = sb.pop_front();
    tests++; if (!ok || ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL refetch_pop got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
  endtask

  task automatic test_stall();
    exp_t e;
    bit   ok;
    int   n;
    rsp_delay = 1;
    do_reset();
    sb_load(8'h00, 16);
    n = 0;
    while (q_count === 3'd0 && n < 40) begin @(negedge clock); n++; end
    rsp_en = 0;
    serve(ok);
    e = sb.pop_front();
    tests++; if (!ok || ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL stall_first got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
    ir_load = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++; if (fetch_stall !== 1'b1 || ir !== e.op || pc !== e.pc)
        begin fails++; $display("FAIL empty_stall_%0d got st=%b ir=%h pc=%h exp 1 %h %h", i, fetch_stall, ir, pc, e.op, e.pc); end
    end
`ifdef FETCH_BYPASS_EN
    rsp_en = 1;
    n = 0;
    while (mem_valid !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL bypass_stall got %b exp 0", fetch_stall); end
    @(negedge clock); ir_load = 0;
    e = sb.pop_front();
    tests++; if (ir !== e.op || pc !== e.pc || q_count !== 3'd0)
      begin fails++; $display("FAIL bypass_ir got ir=%h pc=%h cnt=%0d exp %h %h 0", ir, pc, q_count, e.op, e.pc); end
`else
    ir_load = 0;
    rsp_en = 1;
    serve(ok);
    e = sb.pop_front();
    tests++; if (!ok || ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL after_stall got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
`endif
  endtask

  task automatic test_flush();
    exp_t e;
    bit   ok;
    int   n;
    rsp_delay = 4;
    do_reset();
    imem[2] = 8'hAA;
    sb_load(8'h00, 16);
    n = 0;
    while (!(rsp_busy === 1'b1 && mem_addr === 8'h02) && n < 100) begin @(negedge clock); n++; end
    tests++; if (mem_addr !== 8'h02) begin fails++; $display("FAIL flush_setup addr got %h exp 02", mem_addr); end
    flush = 1; flush_addr = 8'h40;
    @(negedge clock); flush = 0;
    sb.delete();
    sb_load(8'h40, 8);
    tests++; if (q_count !== 3'd0 || mem_rd !== 1'b0)
      begin fails++; $display("FAIL flush_discard got cnt=%0d rd=%b exp 0 0", q_count, mem_rd); end
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL late_valid rd got %b exp 0", mem_rd); end
    @(negedge clock);
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'h40 || q_count !== 3'd0)
      begin fails++; $display("FAIL flush_target got rd=%b addr=%h cnt=%0d exp 1 40 0", mem_rd, mem_addr, q_count); end
    serve(ok);
    e = sb.pop_front();
    tests++; if (!ok || ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL flush_pop got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
    rsp_delay = 1;
  endtask

  task automatic test_push_pop();
    exp_t e;
    bit   ok;
    int   n;
    rsp_delay = 1;
    do_reset();
    sb_load(8'h00, 16);
    n = 0;
    while (!(q_count === 3'd2 && mem_valid === 1'b1) && n < 60) begin @(negedge clock); n++; end
    ir_load = 1;
    @(negedge clock); ir_load = 0;
    e = sb.pop_front();
    tests++; if (q_count !== 3'd2) begin fails++; $display("FAIL push_pop_count got %0d exp 2", q_count); end
    tests++; if (ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL push_pop_ir got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
    for (int i = 0; i < 3; i++) begin
      serve(ok);
      e = sb.pop_front();
      tests++; if (!ok || ir !== e.op || pc !== e.pc)
        begin fails++; $display("FAIL order_%0d got ir=%h pc=%h exp ir=%h pc=%h", i, ir, pc, e.op, e.pc); end
      last_ir = e.op; last_pc = e.pc;
    end
    n = 0;
    while (q_count === 3'd0 && n < 40) begin @(negedge clock); n++; end
    flush = 1; flush_addr = 8'h20; ir_load = 1;
    @(negedge clock); flush = 0; ir_load = 0;
    tests++; if (ir !== last_ir || pc !== last_pc || q_count !== 3'd0)
      begin fails++; $display("FAIL flush_ir_load got ir=%h pc=%h cnt=%0d exp %h %h 0", ir, pc, q_count, last_ir, last_pc); end
    sb.delete();
    sb_load(8'h20, 4);
    serve(ok);
    e = sb.pop_front();
    tests++; if (!ok || ir !== e.op || pc !== e.pc)
      begin fails++; $display("FAIL flush2_pop got ir=%h pc=%h exp ir=%h pc=%h", ir, pc, e.op, e.pc); end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   ok;
    int   n;
    rsp_delay = 1;
    do_reset();
    flush = 1; flush_addr = 8'hFE;
    @(negedge clock); flush = 0;
    sb.delete();
    sb_load(8'hFE, 3);
    tests++; if (mem_rd !== 1'b1 || mem_addr !== 8'hFE)
      begin fails++; $display("FAIL wrap_req got rd=%b addr=%h exp 1 FE", mem_rd, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      serve(ok);
      e = sb.pop_front();
      tests++; if (!ok || ir !== e.op || pc !== e.pc)
        begin fails++; $display("FAIL wrap_%0d got ir=%h pc=%h exp ir=%h pc=%h", i, ir, pc, e.op, e.pc); end
    end
    tests++; if (req_log.size() < 3 || req_log[0] !== 8'hFE || req_log[1] !== 8'hFF || req_log[2] !== 8'h00)
      begin fails++; $display("FAIL wrap_addrs got n=%0d exp reads FE FF 00", req_log.size()); end
    n = 0;
    while (mem_rd !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    reset = 1;
    @(negedge clock);
    tests++; if (ir !== 8'h00 || pc !== 8'h00 || mem_rd !== 1'b0 || mem_addr !== 8'h00 || q_count !== 3'd0)
      begin fails++; $display("FAIL reset_mid_req got ir=%h pc=%h rd=%b addr=%h cnt=%0d exp all 0", ir, pc, mem_rd, mem_addr, q_count); end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stall();
    test_flush();
    test_push_pop();
    test_wrap();
    tests++; if (ovf_seen) begin fails++; $display("FAIL overflow q_count exceeded 4"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
